// File: rtl/vga_timing_core.sv
// Raster timing generator: pixel/line counters, sync pulses and blanking flags for two
// selectable VGA timing modes, with mode switches applied only at frame boundaries.
module vga_timing_core #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned M0_HFP   = 16,
  parameter int unsigned M0_HS    = 96,
  parameter int unsigned M0_HBP   = 48,
  parameter int unsigned M0_VFP   = 10,
  parameter int unsigned M0_VS    = 2,
  parameter int unsigned M0_VBP   = 33,
  parameter int unsigned M1_HFP   = 16,
  parameter int unsigned M1_HS    = 64,
  parameter int unsigned M1_HBP   = 80,
  parameter int unsigned M1_VFP   = 3,
  parameter int unsigned M1_VS    = 4,
  parameter int unsigned M1_VBP   = 13,
  parameter bit          M0_HPOL  = 1'b0,
  parameter bit          M0_VPOL  = 1'b0,
  parameter bit          M1_HPOL  = 1'b1,
  parameter bit          M1_VPOL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_hmax,
  output logic       o_vmax,
  output logic       o_hblank,
  output logic       o_vblank,
  output logic       o_visible,
  output logic       o_mode,
  output logic [7:0] o_frame
);

  localparam logic [9:0] HACT      = 10'(H_ACTIVE);
  localparam logic [9:0] VACT      = 10'(V_ACTIVE);
  localparam logic [9:0] M0_HLAST  = 10'(H_ACTIVE + M0_HFP + M0_HS + M0_HBP - 1);
  localparam logic [9:0] M0_VLAST  = 10'(V_ACTIVE + M0_VFP + M0_VS + M0_VBP - 1);
  localparam logic [9:0] M0_HS_ON  = 10'(H_ACTIVE + M0_HFP);
  localparam logic [9:0] M0_HS_OFF = 10'(H_ACTIVE + M0_HFP + M0_HS);
  localparam logic [9:0] M0_VS_ON  = 10'(V_ACTIVE + M0_VFP);
  localparam logic [9:0] M0_VS_OFF = 10'(V_ACTIVE + M0_VFP + M0_VS);
  localparam logic [9:0] M1_HLAST  = 10'(H_ACTIVE + M1_HFP + M1_HS + M1_HBP - 1);
  localparam logic [9:0] M1_VLAST  = 10'(V_ACTIVE + M1_VFP + M1_VS + M1_VBP - 1);
  localparam logic [9:0] M1_HS_ON  = 10'(H_ACTIVE + M1_HFP);
  localparam logic [9:0] M1_HS_OFF = 10'(H_ACTIVE + M1_HFP + M1_HS);
  localparam logic [9:0] M1_VS_ON  = 10'(V_ACTIVE + M1_VFP);
  localparam logic [9:0] M1_VS_OFF = 10'(V_ACTIVE + M1_VFP + M1_VS);

  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [7:0] frame_q, frame_d;
  logic       mode_q, mode_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       hmax_q, hmax_d, vmax_q, vmax_d;
  logic       hblank_q, hblank_d, vblank_q, vblank_d, visible_q, visible_d;
  logic       frame_end;

  logic [9:0] hlast, vlast, hs_on, hs_off, vs_on, vs_off;
  logic       hpol, vpol;

  // Timing constants of the mode that will be in effect for the next pixel.
  always_comb begin
    if (mode_d) begin
      hlast  = M1_HLAST;
      vlast  = M1_VLAST;
      hs_on  = M1_HS_ON;
      hs_off = M1_HS_OFF;
      vs_on  = M1_VS_ON;
      vs_off = M1_VS_OFF;
      hpol   = M1_HPOL;
      vpol   = M1_VPOL;
    end else begin
      hlast  = M0_HLAST;
      vlast  = M0_VLAST;
      hs_on  = M0_HS_ON;
      hs_off = M0_HS_OFF;
      vs_on  = M0_VS_ON;
      vs_off = M0_VS_OFF;
      hpol   = M0_HPOL;
      vpol   = M0_VPOL;
    end
  end

  // Wraps key off the registered max flags, so counters follow the mode already in effect.
  always_comb begin
    frame_end = hmax_q & vmax_q;
    mode_d    = frame_end ? mode : mode_q;
    frame_d   = frame_end ? frame_q + 8'd1 : frame_q;
    hpos_d    = hmax_q ? '0 : hpos_q + 10'd1;
    vpos_d    = vpos_q;
    if (hmax_q) begin
      vpos_d = vmax_q ? '0 : vpos_q + 10'd1;
    end
    hmax_d    = (hpos_d == hlast);
    vmax_d    = (vpos_d == vlast);
    hblank_d  = (hpos_d >= HACT);
    vblank_d  = (vpos_d >= VACT);
    visible_d = ~hblank_d & ~vblank_d;
    hsync_d   = ((hpos_d >= hs_on) && (hpos_d < hs_off)) ? hpol : ~hpol;
    vsync_d   = ((vpos_d >= vs_on) && (vpos_d < vs_off)) ? vpol : ~vpol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q    <= '0;
      vpos_q    <= '0;
      frame_q   <= '0;
      mode_q    <= 1'b0;
      hmax_q    <= 1'b0;
      vmax_q    <= 1'b0;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      visible_q <= 1'b1;
      hsync_q   <= ~M0_HPOL;
      vsync_q   <= ~M0_VPOL;
    end else begin
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      frame_q   <= frame_d;
      mode_q    <= mode_d;
      hmax_q    <= hmax_d;
      vmax_q    <= vmax_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      visible_q <= visible_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign o_hpos    = hpos_q;
  assign o_vpos    = vpos_q;
  assign o_frame   = frame_q;
  assign o_mode    = mode_q;
  assign o_hmax    = hmax_q;
  assign o_vmax    = vmax_q;
  assign o_hblank  = hblank_q;
  assign o_vblank  = vblank_q;
  assign o_visible = visible_q;
  assign o_hsync   = hsync_q;
  assign o_vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench: full-size instance checks the first line of mode 0; a scaled instance
// (15x8 / 14x9 rasters) exercises frame-level behaviour, mode switching, wrap and reset.
module tb_vga_timing_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full-size instance
  logic       rst_a_n, mode_a;
  logic [9:0] a_hpos, a_vpos;
  logic [7:0] a_frame;
  logic       a_hsync, a_vsync, a_hmax, a_vmax, a_hblank, a_vblank, a_visible, a_mode;

  vga_timing_core u_full (
    .clk      (clk),
    .rst_n    (rst_a_n),
    .mode     (mode_a),
    .o_hpos   (a_hpos),
    .o_vpos   (a_vpos),
    .o_hsync  (a_hsync),
    .o_vsync  (a_vsync),
    .o_hmax   (a_hmax),
    .o_vmax   (a_vmax),
    .o_hblank (a_hblank),
    .o_vblank (a_vblank),
    .o_visible(a_visible),
    .o_mode   (a_mode),
    .o_frame  (a_frame)
  );

  // Scaled instance: mode 0 total 15x8, mode 1 total 14x9, 8x4 active.
  logic       rst_b_n, mode_b;
  logic [9:0] b_hpos, b_vpos;
  logic [7:0] b_frame;
  logic       b_hsync, b_vsync, b_hmax, b_vmax, b_hblank, b_vblank, b_visible, b_mode;

  vga_timing_core #(
    .H_ACTIVE(8), .V_ACTIVE(4),
    .M0_HFP(2), .M0_HS(3), .M0_HBP(2), .M0_VFP(1), .M0_VS(2), .M0_VBP(1),
    .M1_HFP(1), .M1_HS(2), .M1_HBP(3), .M1_VFP(2), .M1_VS(1), .M1_VBP(2)
  ) u_small (
    .clk      (clk),
    .rst_n    (rst_b_n),
    .mode     (mode_b),
    .o_hpos   (b_hpos),
    .o_vpos   (b_vpos),
    .o_hsync  (b_hsync),
    .o_vsync  (b_vsync),
    .o_hmax   (b_hmax),
    .o_vmax   (b_vmax),
    .o_hblank (b_hblank),
    .o_vblank (b_vblank),
    .o_visible(b_visible),
    .o_mode   (b_mode),
    .o_frame  (b_frame)
  );

  int st_cycles, st_vis, st_hs_cnt, st_hs_first, st_hs_last;
  int st_vs_cnt, st_vs_first, st_vs_last, st_hmax, st_vmax, st_mode_bad;

  // Runs the scaled instance from pixel (0,0) until o_frame changes, gathering statistics.
  // At (ev_line,0) mode_b is driven to ev_val; if ev_len>0 it reverts after ev_len cycles.
  task automatic run_frame(input logic exp_mode, input logic pol, input int ev_line,
                           input logic ev_val, input int ev_len);
    logic [7:0] f0;
    int left;
    st_cycles = 0; st_vis = 0; st_hs_cnt = 0; st_hs_first = -1; st_hs_last = -1;
    st_vs_cnt = 0; st_vs_first = -1; st_vs_last = -1; st_hmax = 0; st_vmax = 0;
    st_mode_bad = 0;
    left = 0;
    f0 = b_frame;
    while (b_frame == f0 && st_cycles < 1000) begin
      if (b_visible) st_vis++;
      if (b_hsync == pol) begin
        st_hs_cnt++;
        if (st_hs_first < 0) st_hs_first = int'(b_hpos);
        st_hs_last = int'(b_hpos);
      end
      if (b_vsync == pol) begin
        st_vs_cnt++;
        if (st_vs_first < 0) st_vs_first = int'(b_vpos);
        st_vs_last = int'(b_vpos);
      end
      if (b_hmax) st_hmax++;
      if (b_vmax) st_vmax++;
      if (b_mode != exp_mode) st_mode_bad++;
      if (int'(b_vpos) == ev_line && b_hpos == 10'd0) begin
        mode_b = ev_val;
        left = ev_len;
      end else if (left > 0) begin
        left--;
        if (left == 0) mode_b = ~ev_val;
      end
      @(posedge clk);
      @(negedge clk);
      st_cycles++;
    end
  endtask

  int hmax_cnt, hmax_at, hblank_first, hs_first, hs_last, hs_cnt, vis_cnt;
  int tot_cycles, tot_vis;
  logic [7:0] frame_mid;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values on the full-size instance
    check("rst_hpos", a_hpos, 0);
    check("rst_vpos", a_vpos, 0);
    check("rst_frame", a_frame, 0);
    check("rst_mode", a_mode, 0);
    check("rst_flags", {a_hmax, a_vmax, a_hblank, a_vblank, a_visible}, 5'b00001);
    check("rst_sync", {a_hsync, a_vsync}, 2'b11);

    // First line of mode 0
    rst_a_n = 1'b1;
    hmax_cnt = 0; hmax_at = -1; hblank_first = -1; hs_first = -1; hs_last = -1;
    hs_cnt = 0; vis_cnt = 0;
    for (int i = 1; i <= 800; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) check("first_clk_pos", {a_vpos, a_hpos}, {10'd0, 10'd1});
      if (a_hmax) begin hmax_cnt++; hmax_at = int'(a_hpos); end
      if (a_hblank && hblank_first < 0) hblank_first = int'(a_hpos);
      if (!a_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_hpos);
        hs_last = int'(a_hpos);
      end
      if (a_visible) vis_cnt++;
    end
    check("line_end_hpos", a_hpos, 0);
    check("line_end_vpos", a_vpos, 1);
    check("hmax_count", hmax_cnt, 1);
    check("hmax_at", hmax_at, 799);
    check("hblank_rise", hblank_first, 640);
    check("hsync_first", hs_first, 656);
    check("hsync_last", hs_last, 751);
    check("hsync_len", hs_cnt, 96);
    check("line_visible", vis_cnt, 640);
    check("line_vsync_idle", a_vsync, 1);

    // Scaled instance: plain mode 0 frame
    rst_b_n = 1'b1;
    run_frame(1'b0, 1'b0, -1, 1'b0, 0);
    check("f0_cycles", st_cycles, 120);
    check("f0_visible", st_vis, 32);
    check("f0_hs_first", st_hs_first, 10);
    check("f0_hs_last", st_hs_last, 12);
    check("f0_hs_cnt", st_hs_cnt, 24);
    check("f0_vs_first", st_vs_first, 5);
    check("f0_vs_last", st_vs_last, 6);
    check("f0_vs_cnt", st_vs_cnt, 30);
    check("f0_hmax_cnt", st_hmax, 8);
    check("f0_vmax_cnt", st_vmax, 15);
    check("f0_frame", b_frame, 1);

    // Five-cycle mode pulse mid-frame must be ignored
    run_frame(1'b0, 1'b0, 3, 1'b1, 5);
    check("f1_cycles", st_cycles, 120);
    check("f1_mode_bad", st_mode_bad, 0);
    check("f1_mode_after", b_mode, 0);
    check("f1_frame", b_frame, 2);

    // Request mode 1 at line 2: takes effect only at the frame end
    run_frame(1'b0, 1'b0, 2, 1'b1, 0);
    check("f2_cycles", st_cycles, 120);
    check("f2_mode_bad", st_mode_bad, 0);
    check("f2_mode_after", b_mode, 1);

    // Mode 1 frame; request mode 0 again at line 1
    run_frame(1'b1, 1'b1, 1, 1'b0, 0);
    check("f3_cycles", st_cycles, 126);
    check("f3_visible", st_vis, 32);
    check("f3_hs_first", st_hs_first, 9);
    check("f3_hs_last", st_hs_last, 10);
    check("f3_hs_cnt", st_hs_cnt, 18);
    check("f3_vs_first", st_vs_first, 6);
    check("f3_vs_last", st_vs_last, 6);
    check("f3_vs_cnt", st_vs_cnt, 14);
    check("f3_hmax_cnt", st_hmax, 9);
    check("f3_vmax_cnt", st_vmax, 14);
    check("f3_mode_bad", st_mode_bad, 0);
    check("f3_mode_after", b_mode, 0);
    check("f3_frame", b_frame, 4);

    // 252 more mode 0 frames: counter reaches 255 then wraps to 0
    tot_cycles = 0; tot_vis = 0; frame_mid = 8'd0;
    for (int j = 0; j < 252; j++) begin
      run_frame(1'b0, 1'b0, -1, 1'b0, 0);
      tot_cycles += st_cycles;
      tot_vis += st_vis;
      if (j == 250) frame_mid = b_frame;
    end
    check("wrap_frame_255", frame_mid, 255);
    check("wrap_frame_0", b_frame, 0);
    check("wrap_cycles", tot_cycles, 252 * 120);
    check("wrap_visible", tot_vis, 252 * 32);

    // Switch to mode 1, then reset mid-frame at (5,2)
    run_frame(1'b0, 1'b0, 1, 1'b1, 0);
    check("pre_rst_mode", b_mode, 1);
    for (int k = 0; k < 500 && !(b_hpos == 10'd5 && b_vpos == 10'd2); k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("seek_pos", {b_vpos, b_hpos}, {10'd2, 10'd5});
    check("pre_rst_hsync", b_hsync, 0);
    check("pre_rst_frame", b_frame, 1);
    rst_b_n = 1'b0;
    #1;
    check("async_rst_pos", {b_vpos, b_hpos}, 0);
    check("async_rst_frame", b_frame, 0);
    check("async_rst_mode", b_mode, 0);
    check("async_rst_flags", {b_hmax, b_vmax, b_hblank, b_vblank, b_visible}, 5'b00001);
    check("async_rst_sync", {b_hsync, b_vsync}, 2'b11);
    @(negedge clk);
    rst_b_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rerelease_pos", {b_vpos, b_hpos}, {10'd0, 10'd1});
    check("rerelease_mode", b_mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
